ewrapper_io_tx_serializer: RTL and testbench

Transmit-side counterpart of the eLink receive deserializer. It accepts 72-bit parallel words (9 lanes × 8 bits) through a valid/ready handshake and serializes each word over four fast-clock cycles. Each lane produces an even/odd bit pair per cycle, which drives the per-lane ODDR/OBUFDS stage in the IO wrapper. It also emits a divide-by-4 frame clock pattern, so the far-end receiver's slow-clock edge detection lands on slot 0 of every word.

---
 rtl/ewrapper_io_tx_serializer_pkg.sv | 23 ++
 rtl/ewrapper_io_tx_serializer_if.sv | 22 ++
 rtl/ewrapper_tx_fifo2.sv | 56 +++++
 rtl/ewrapper_io_tx_serializer.sv | 109 ++++++++++
 tb/tb_ewrapper_io_tx_serializer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ewrapper_io_tx_serializer_pkg.sv
// ----------------------------------------------------------------------------
// ewrapper_io_tx_serializer_pkg
// Shared definitions for the eLink transmit serializer and receive
// deserializer. The slot-mapping function is the one definition of which word
// bit travels on which lane in which phase.
//   NLANES        : number of serial lanes
//   PHASES        : fast-clock cycles per parallel word
//   BITS_PER_LANE : bits each lane carries per word (MSB first)
//   slot_bit()    : (lane, phase, odd) -> bit index inside the parallel word
// ----------------------------------------------------------------------------
package ewrapper_io_tx_serializer_pkg;

    localparam int NLANES        = 9;
    localparam int PHASES        = 4;
    localparam int BITS_PER_LANE = 8;

    // Phase k carries bits 7-2k (even, rising edge) and 6-2k (odd, falling
    // edge) of each lane's byte.
    function automatic int slot_bit(input int lane, input int phase, input bit odd);
        return BITS_PER_LANE * lane + (BITS_PER_LANE - 1) - 2 * phase - int'(odd);
    endfunction

endpackage

// File: rtl/ewrapper_io_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// ewrapper_io_tx_serializer_if
// Valid/ready word interface into the transmit serializer.
//   tx_data  : parallel word, lane p owns bits [8p+7:8p]
//   tx_valid : tx_data valid
//   tx_ready : serializer queue can accept a word this cycle
// master = word producer, slave = serializer.
// ----------------------------------------------------------------------------
interface ewrapper_io_tx_serializer_if
    import ewrapper_io_tx_serializer_pkg::*;
#(
    parameter int NLANES = ewrapper_io_tx_serializer_pkg::NLANES
);

    logic [BITS_PER_LANE*NLANES-1:0] tx_data;
    logic                            tx_valid;
    logic                            tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/ewrapper_tx_fifo2.sv
// ----------------------------------------------------------------------------
// ewrapper_tx_fifo2
// Two-entry queue feeding the serializer's shift register.
//   rxi_lclk, reset : clock, asynchronous active-high reset
//   push, push_data : write one word (caller guarantees not full)
//   pop             : drop the head word (caller guarantees not empty)
//   full, empty     : occupancy flags from the registered count
//   head            : oldest stored word
// ----------------------------------------------------------------------------
module ewrapper_tx_fifo2 #(
    parameter int W = 72
) (
    input  logic         rxi_lclk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage carries no reset; contents are only observed through
    // count, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge rxi_lclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ewrapper_io_tx_serializer.sv
// ----------------------------------------------------------------------------
// ewrapper_io_tx_serializer
// Serializes 72-bit words (9 lanes x 8 bits) over four rxi_lclk cycles as
// per-lane even/odd DDR bit pairs for the ODDR/OBUFDS stage in the IO wrapper.
//   rxi_lclk, reset : fast link clock, asynchronous active-high reset
//   elink_invert    : quasi-static lane data inversion (1 for E64)
//   tx_if           : valid/ready word input (slave modport)
//   tx_even/tx_odd  : per-lane rising/falling-edge bit of the current cycle
//   tx_clk_div      : frame clock pattern 1,1,0,0
//   tx_frame_start  : high in phase 0 of every word
//   tx_underrun     : sticky flag, a data word was followed by idle
//   underrun_clr    : synchronous clear of tx_underrun
// ----------------------------------------------------------------------------
module ewrapper_io_tx_serializer
    import ewrapper_io_tx_serializer_pkg::*;
#(
    parameter int                                NLANES    = ewrapper_io_tx_serializer_pkg::NLANES,
    parameter logic [BITS_PER_LANE*NLANES-1:0]   IDLE_WORD = '0
) (
    input  logic                       rxi_lclk,
    input  logic                       reset,
    input  logic                       elink_invert,
    ewrapper_io_tx_serializer_if.slave tx_if,
    output logic [NLANES-1:0]          tx_even,
    output logic [NLANES-1:0]          tx_odd,
    output logic                       tx_clk_div,
    output logic                       tx_frame_start,
    output logic                       tx_underrun,
    input  logic                       underrun_clr
);

    localparam int DW = BITS_PER_LANE * NLANES;
    localparam int IW = $clog2(DW);
    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

    logic [PW-1:0]     phase;
    logic [PW-1:0]     next_phase;
    logic [DW-1:0]     word;
    logic [DW-1:0]     next_word;
    logic [NLANES-1:0] next_even;
    logic [NLANES-1:0] next_odd;
    logic              last_load_data;
    logic              load;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_head;

    // Ready is forced low while reset is held so no word slips into a queue
    // that is about to be discarded.
    assign tx_if.tx_ready = ~reset & ~fifo_full;
    assign push           = tx_if.tx_valid & tx_if.tx_ready;
    assign load           = (phase == PH_LAST);
    assign pop            = load & ~fifo_empty;

    ewrapper_tx_fifo2 #(.W(DW)) u_fifo (
        .rxi_lclk  (rxi_lclk),
        .reset     (reset),
        .push      (push),
        .push_data (tx_if.tx_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Outputs are registered, so the slot bits are selected from the word and
    // phase that will be current after this edge.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_phase = PW'(phase + 1'b1);
        next_word  = word;
        next_even  = '0;
        next_odd   = '0;
        if (load) next_word = fifo_empty ? IDLE_WORD : fifo_head;
        for (int p = 0; p < NLANES; p++) begin
            next_even[p] = next_word[IW'(slot_bit(p, int'(next_phase), 1'b0))] ^ elink_invert;
            next_odd[p]  = next_word[IW'(slot_bit(p, int'(next_phase), 1'b1))] ^ elink_invert;
        end
    end

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            phase          <= PH_LAST;
            word           <= '0;
            tx_even        <= '0;
            tx_odd         <= '0;
            tx_clk_div     <= 1'b0;
            tx_frame_start <= 1'b0;
            last_load_data <= 1'b0;
            tx_underrun    <= 1'b0;
        end else begin
            phase          <= next_phase;
            word           <= next_word;
            tx_even        <= next_even;
            tx_odd         <= next_odd;
            tx_clk_div     <= (next_phase < PW'(2));
            tx_frame_start <= (next_phase == '0);
            if (load) last_load_data <= ~fifo_empty;
            // Set takes priority over a same-edge clear.
            if (load && fifo_empty && last_load_data) tx_underrun <= 1'b1;
            else if (underrun_clr)                    tx_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ewrapper_io_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_ewrapper_io_tx_serializer
// Directed and randomized stimulus against a frame-level reference model:
// a queue of pending words, the word on the wire and its slot number.
// ----------------------------------------------------------------------------
module tb_ewrapper_io_tx_serializer;

    localparam int NL = 9;
    localparam int DW = 8 * NL;
    localparam logic [DW-1:0] IDLE = '0;

    logic          rxi_lclk = 1'b0;
    logic          reset;
    logic          elink_invert;
    logic          underrun_clr;
    logic [NL-1:0] tx_even;
    logic [NL-1:0] tx_odd;
    logic          tx_clk_div;
    logic          tx_frame_start;
    logic          tx_underrun;

    ewrapper_io_tx_serializer_if #(.NLANES(NL)) tx_if ();

    ewrapper_io_tx_serializer #(.NLANES(NL), .IDLE_WORD(IDLE)) dut (
        .rxi_lclk       (rxi_lclk),
        .reset          (reset),
        .elink_invert   (elink_invert),
        .tx_if          (tx_if),
        .tx_even        (tx_even),
        .tx_odd         (tx_odd),
        .tx_clk_div     (tx_clk_div),
        .tx_frame_start (tx_frame_start),
        .tx_underrun    (tx_underrun),
        .underrun_clr   (underrun_clr)
    );

    always #5 rxi_lclk = ~rxi_lclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_word;
    int            m_slot;
    bit            m_started;
    bit            m_last_data;
    bit            m_underrun;
    bit            m_inv;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_word      = '0;
        m_slot      = 3;
        m_started   = 0;
        m_last_data = 0;
        m_underrun  = 0;
        m_inv       = 0;
    endtask

    // Compare every output against the model (called at the falling edge).
    task automatic check_all(input string tag);
        logic [NL-1:0] ee, eo;
        ee = '0;
        eo = '0;
        if (m_started) begin
            for (int p = 0; p < NL; p++) begin
                ee[p] = m_word[8*p + 7 - 2*m_slot] ^ m_inv;
                eo[p] = m_word[8*p + 6 - 2*m_slot] ^ m_inv;
            end
        end
        check({tag, ".even"},  DW'(tx_even), DW'(ee));
        check({tag, ".odd"},   DW'(tx_odd),  DW'(eo));
        check({tag, ".clk"},   DW'(tx_clk_div),     DW'(m_started && m_slot < 2));
        check({tag, ".fs"},    DW'(tx_frame_start), DW'(m_started && m_slot == 0));
        check({tag, ".ur"},    DW'(tx_underrun),    DW'(m_underrun));
        check({tag, ".ready"}, DW'(tx_if.tx_ready), DW'(!reset && m_q.size() < 2));
    endtask

    // One rising edge: the model applies the frame rules to the inputs seen
    // at that edge, then outputs are compared at the next falling edge.
    task automatic cyc(input string tag);
        bit push, set_ur;
        @(posedge rxi_lclk);
        push   = tx_if.tx_valid && (m_q.size() < 2);
        set_ur = 0;
        if (m_slot == 3) begin
            if (m_q.size() != 0) begin
                m_word      = m_q.pop_front();
                m_last_data = 1;
            end else begin
                m_word      = IDLE;
                set_ur      = m_last_data;
                m_last_data = 0;
            end
        end
        if (set_ur)            m_underrun = 1;
        else if (underrun_clr) m_underrun = 0;
        if (push) m_q.push_back(tx_if.tx_data);
        m_slot    = (m_slot + 1) % 4;
        m_started = 1;
        m_inv     = elink_invert;
        @(negedge rxi_lclk);
        check_all(tag);
    endtask

    task automatic align(input int slot);
        for (int i = 0; i < 4 && m_slot != slot; i++) cyc("align");
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] w;
    logic [DW-1:0] words[5];
    logic [3:0]    exp_e8;
    logic [3:0]    exp_o8;

    initial begin
        reset             = 1'b1;
        elink_invert      = 1'b0;
        underrun_clr      = 1'b0;
        tx_if.tx_valid    = 1'b0;
        tx_if.tx_data     = '0;
        model_reset();
        repeat (3) @(negedge rxi_lclk);
        check_all("reset");

        // Idle after reset: 16 cycles with a 1,1,0,0 frame clock.
        reset = 1'b0;
        #1;
        check("ready_after_release", DW'(tx_if.tx_ready), DW'(1));
        for (int i = 0; i < 16; i++) begin
            cyc("idle");
            check("clk_div_pattern", DW'(tx_clk_div), DW'((i % 4) < 2));
        end

        // Single word in lane 8, plain then inverted polarity.
        for (int pass = 0; pass < 2; pass++) begin
            elink_invert = (pass == 1);
            exp_e8 = (pass == 0) ? 4'b0011 : 4'b1100;  // bit k = phase k
            exp_o8 = ~exp_e8;
            align(0);
            w = {8'hA5, 64'h0};
            tx_if.tx_data  = w;
            tx_if.tx_valid = 1'b1;
            cyc("single_push");
            tx_if.tx_valid = 1'b0;
            for (int i = 0; i < 8 && !(m_slot == 0 && m_word == w); i++) cyc("single_wait");
            for (int k = 0; k < 4; k++) begin
                check("lane8_even", DW'(tx_even[8]), DW'(exp_e8[k]));
                check("lane8_odd",  DW'(tx_odd[8]),  DW'(exp_o8[k]));
                check("lanes0_7",   DW'(tx_even[7:0]), (pass == 0) ? DW'(0) : DW'(8'hFF));
                cyc("single_slot");
            end
            repeat (4) cyc("single_tail");
            check("underrun_set", DW'(tx_underrun), DW'(1));
            underrun_clr = 1'b1;
            cyc("clr");
            underrun_clr = 1'b0;
            check("underrun_cleared", DW'(tx_underrun), DW'(0));
        end
        elink_invert = 1'b0;
        repeat (4) cyc("pol_settle");

        // Five back-to-back words with tx_valid held high.
        for (int i = 0; i < 5; i++) words[i] = rnd_word();
        align(0);
        begin
            int idx = 0;
            int pushes = 0;
            tx_if.tx_valid = 1'b1;
            for (int c = 0; c < 60 && idx < 5; c++) begin
                bit will_push;
                tx_if.tx_data = words[idx];
                will_push = (m_q.size() < 2);
                cyc("stream");
                if (will_push) begin
                    idx++;
                    pushes++;
                    if (pushes == 2) check("ready_low_after_2", DW'(tx_if.tx_ready), DW'(0));
                end
            end
            tx_if.tx_valid = 1'b0;
        end
        repeat (12) cyc("stream_drain");
        check("stream_underrun", DW'(tx_underrun), DW'(1));
        underrun_clr = 1'b1;
        cyc("clr2");
        underrun_clr = 1'b0;

        // Push on the edge that ends phase 3: that frame stays idle.
        align(3);
        w = rnd_word();
        tx_if.tx_data  = w;
        tx_if.tx_valid = 1'b1;
        cyc("p3_push");
        tx_if.tx_valid = 1'b0;
        check("p3_idle_frame_fs", DW'(tx_frame_start), DW'(1));
        check("p3_idle_frame_even", DW'(tx_even), DW'(0));
        repeat (3) cyc("p3_wait");
        cyc("p3_slot0");
        for (int p = 0; p < NL; p++)
            check("p3_word_slot0", DW'({tx_even[p], tx_odd[p]}), DW'({w[8*p+7], w[8*p+6]}));
        repeat (8) cyc("p3_tail");
        underrun_clr = 1'b1;
        cyc("clr3");
        underrun_clr = 1'b0;

        // Reset in phase 2 of a data word with another word queued.
        align(0);
        tx_if.tx_data  = rnd_word();
        tx_if.tx_valid = 1'b1;
        cyc("rst_push_a");
        tx_if.tx_valid = 1'b0;
        align(0);
        tx_if.tx_data  = rnd_word();
        tx_if.tx_valid = 1'b1;
        cyc("rst_push_b");
        tx_if.tx_valid = 1'b0;
        cyc("rst_slot2");
        #2 reset = 1'b1;
        #1;
        check("async_even",  DW'(tx_even), DW'(0));
        check("async_odd",   DW'(tx_odd), DW'(0));
        check("async_clk",   DW'(tx_clk_div), DW'(0));
        check("async_fs",    DW'(tx_frame_start), DW'(0));
        check("async_ready", DW'(tx_if.tx_ready), DW'(0));
        model_reset();
        @(negedge rxi_lclk);
        check_all("in_reset");
        reset = 1'b0;
        repeat (12) cyc("post_reset");

        // Randomized traffic with occasional clears and polarity flips.
        for (int c = 0; c < 400; c++) begin
            tx_if.tx_valid = ($urandom_range(0, 3) != 0);
            tx_if.tx_data  = rnd_word();
            underrun_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) elink_invert = ~elink_invert;
            cyc("random");
        end
        tx_if.tx_valid = 1'b0;
        underrun_clr   = 1'b0;
        repeat (12) cyc("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
